// File: rtl/dbg_bridge_pkg.sv
// Shared opcodes, FSM state encoding and response tags for the debug bus bridge.
package dbg_bridge_pkg;

  localparam logic [3:0] OP_STATUS = 4'h0;
  localparam logic [3:0] OP_ADDR   = 4'h1;
  localparam logic [3:0] OP_READ   = 4'h2;
  localparam logic [3:0] OP_WLO    = 4'h3;
  localparam logic [3:0] OP_WHI    = 4'h4;

  localparam logic [31:0] RESP_BAD  = 32'hBAD0_0000;
  localparam logic [31:0] RESP_DEAD = 32'hDEAD_0000;

  localparam int unsigned TMR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dbg_bridge_timer.sv
// Loadable down-counter with terminal-count flag; bounds how long a bus op may wait.
module dbg_bridge_timer
  import dbg_bridge_pkg::*;
#(
  parameter int unsigned W = TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/dbg_bus_bridge.sv
// Executes JTAG debug-port command words as register-bus reads/writes and returns results.
// Optional bus timeout is enabled by defining DBG_BUS_BRIDGE_TIMEOUT_EN.
module dbg_bus_bridge
  import dbg_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       cmd_data,
  input  logic              cmd_valid,
  output logic [31:0]       resp_data,
  output logic              resp_we,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
    $error("dbg_bus_bridge: TIMEOUT must be within 1..65535");
  end

  // Handshake: a bus transfer completes at the first edge where bus_req && bus_ack;
  // cmd_valid and resp_we are single-cycle strobes with no back-pressure.
  state_t            state_q, state_d;
  logic [3:0]        op;
  logic              accept;
  logic              bus_op;
  logic              tmo_hit;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] addr_new;
  logic [ADDR_W-1:0] addr_inc;
  logic [31:0]       wdata_reg;
  logic              ovr_q;
  logic              tmo_q;
  logic              inc_q;
  logic              unused_cmd;

  assign op         = cmd_data[31:28];
  assign bus_op     = (op == OP_READ) || (op == OP_WHI);
  assign addr_new   = {cmd_data[ADDR_W-1:2], 2'b00};
  assign addr_inc   = addr_reg + ADDR_W'(4);
  assign unused_cmd = ^cmd_data[26:16];

  assign bus_req = (state_q == BUS);
  assign resp_we = (state_q == RESP);

`ifdef DBG_BUS_BRIDGE_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TIMEOUT - 1);
  logic tmr_tc;

  dbg_bridge_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept && bus_op),
    .load_val (TMO_LOAD),
    .en       (state_q == BUS),
    .tc       (tmr_tc)
  );

  assign tmo_hit = (state_q == BUS) && tmr_tc;
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = bus_op ? BUS : RESP;
        end
      end
      BUS:     if (bus_ack || tmo_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      ovr_q     <= 1'b0;
      tmo_q     <= 1'b0;
      inc_q     <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      resp_data <= '0;
    end else begin
      // Commands arriving while busy are discarded but leave a sticky trace.
      if (cmd_valid && (state_q != IDLE)) ovr_q <= 1'b1;

      if (accept) begin
        case (op)
          OP_STATUS: begin
            resp_data <= {4'h0, 10'h0, ovr_q, tmo_q, 16'(addr_reg)};
            ovr_q     <= 1'b0;
            tmo_q     <= 1'b0;
          end
          OP_ADDR: begin
            addr_reg  <= addr_new;
            resp_data <= {4'h1, 12'h0, 16'(addr_new)};
          end
          OP_READ: begin
            bus_we   <= 1'b0;
            bus_addr <= addr_reg;
            inc_q    <= cmd_data[27];
          end
          OP_WLO: begin
            wdata_reg[15:0] <= cmd_data[15:0];
            resp_data       <= {4'h3, 12'h0, cmd_data[15:0]};
          end
          OP_WHI: begin
            wdata_reg[31:16] <= cmd_data[15:0];
            bus_wdata        <= {cmd_data[15:0], wdata_reg[15:0]};
            bus_we           <= 1'b1;
            bus_addr         <= addr_reg;
            inc_q            <= cmd_data[27];
          end
          default: resp_data <= RESP_BAD | {28'h0, op};
        endcase
      end

      if (state_q == BUS) begin
        // An ack in the terminal-count cycle wins over the timeout.
        if (bus_ack) begin
          resp_data <= bus_we ? {4'h4, 12'h0, 16'(bus_addr)} : bus_rdata;
          if (inc_q) addr_reg <= addr_inc;
        end else if (tmo_hit) begin
          tmo_q     <= 1'b1;
          resp_data <= RESP_DEAD | {16'h0, 16'(bus_addr)};
        end
      end
    end
  end

endmodule

// File: tb/tb_dbg_bus_bridge.sv
// Directed self-checking bench for dbg_bus_bridge (timeout scenarios follow DBG_BUS_BRIDGE_TIMEOUT_EN).
module tb_dbg_bus_bridge;

  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       cmd_data;
  logic              cmd_valid;
  logic [31:0]       resp_data;
  logic              resp_we;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;
  logic              bus_ack;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dbg_bus_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .resp_data (resp_data),
    .resp_we   (resp_we),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] w);
    cmd_data  = w;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic ack_bus(input logic [31:0] d);
    bus_rdata = d;
    bus_ack   = 1'b1;
    tick();
    bus_ack   = 1'b0;
    bus_rdata = '0;
  endtask

  task automatic wait_resp(output logic [31:0] d, output bit ok);
    ok = 1'b0;
    d  = '0;
    for (int i = 0; i < 40; i++) begin
      if (resp_we) begin
        ok = 1'b1;
        d  = resp_data;
        break;
      end
      tick();
    end
  endtask

  task automatic run_cmd(input logic [31:0] w, output logic [31:0] d, output bit ok);
    issue(w);
    wait_resp(d, ok);
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; cmd_data = '0; cmd_valid = 1'b0; bus_rdata = '0; bus_ack = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({bus_req, bus_we, resp_we} !== 3'b000)
      $display("FAIL reset_strobes: got %b want 000", {bus_req, bus_we, resp_we});
    else n_pass++;
    n_checks++;
    if ({bus_addr, bus_wdata, resp_data} !== '0)
      $display("FAIL reset_data: got %h/%h/%h want 0", bus_addr, bus_wdata, resp_data);
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_inc();
    logic [31:0] d; bit ok;
    run_cmd(32'h1000_0010, d, ok);
    n_checks++;
    if (!ok || d !== 32'h1000_0010) $display("FAIL addr_resp: got %h ok=%0b want 10000010", d, ok);
    else n_pass++;
    issue(32'h2800_0000);
    n_checks++;
    if ({bus_req, bus_we, bus_addr} !== {1'b1, 1'b0, 16'h0010})
      $display("FAIL read_bus: got req=%b we=%b addr=%h want 1 0 0010", bus_req, bus_we, bus_addr);
    else n_pass++;
    tick(); tick();
    ack_bus(32'hCAFE_F00D);
    n_checks++;
    if (bus_req !== 1'b0) $display("FAIL read_req_drop: got %b want 0", bus_req);
    else n_pass++;
    wait_resp(d, ok);
    n_checks++;
    if (!ok || d !== 32'hCAFE_F00D) $display("FAIL read_data: got %h ok=%0b want cafef00d", d, ok);
    else n_pass++;
    tick();
    n_checks++;
    if (resp_we !== 1'b0) $display("FAIL read_single_strobe: got %b want 0", resp_we);
    else n_pass++;
    run_cmd(32'h0000_0000, d, ok);
    n_checks++;
    if (!ok || d !== 32'h0000_0014) $display("FAIL status_after_inc: got %h ok=%0b want 00000014", d, ok);
    else n_pass++;
  endtask

  task automatic test_write();
    logic [31:0] d; bit ok;
    run_cmd(32'h3000_5678, d, ok);
    n_checks++;
    if (!ok || d !== 32'h3000_5678) $display("FAIL wlo_resp: got %h ok=%0b want 30005678", d, ok);
    else n_pass++;
    issue(32'h4000_1234);
    n_checks++;
    if ({bus_req, bus_we, bus_addr, bus_wdata} !== {2'b11, 16'h0014, 32'h1234_5678})
      $display("FAIL write_bus: got req=%b we=%b addr=%h wdata=%h want 1 1 0014 12345678",
               bus_req, bus_we, bus_addr, bus_wdata);
    else n_pass++;
    tick();
    ack_bus(32'h0);
    wait_resp(d, ok);
    n_checks++;
    if (!ok || d !== 32'h4000_0014) $display("FAIL write_resp: got %h ok=%0b want 40000014", d, ok);
    else n_pass++;
    tick();
  endtask

  task automatic test_ack_ignored();
    logic [31:0] d; bit ok;
    bus_ack = 1'b1;
    tick(); tick();
    n_checks++;
    if ({bus_req, resp_we} !== 2'b00) $display("FAIL stray_ack: got %b want 00", {bus_req, resp_we});
    else n_pass++;
    bus_ack = 1'b0;
    run_cmd(32'h0000_0000, d, ok);
    n_checks++;
    if (!ok || d !== 32'h0000_0014) $display("FAIL stray_ack_status: got %h ok=%0b want 00000014", d, ok);
    else n_pass++;
  endtask

`ifdef DBG_BUS_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] d; bit ok; int cnt;
    run_cmd(32'h1000_0020, d, ok);
    issue(32'h2000_0000);
    cnt = 0;
    while (bus_req && cnt < 50) begin
      cnt++;
      tick();
    end
    n_checks++;
    if (cnt !== TIMEOUT) $display("FAIL tmo_req_cycles: got %0d want %0d", cnt, TIMEOUT);
    else n_pass++;
    wait_resp(d, ok);
    n_checks++;
    if (!ok || d !== 32'hDEAD_0020) $display("FAIL tmo_resp: got %h ok=%0b want dead0020", d, ok);
    else n_pass++;
    tick();
    run_cmd(32'h0000_0000, d, ok);
    n_checks++;
    if (!ok || d !== 32'h0001_0020) $display("FAIL tmo_status_set: got %h ok=%0b want 00010020", d, ok);
    else n_pass++;
    run_cmd(32'h0000_0000, d, ok);
    n_checks++;
    if (!ok || d !== 32'h0000_0020) $display("FAIL tmo_status_clr: got %h ok=%0b want 00000020", d, ok);
    else n_pass++;
    // Ack exactly in the terminal-count cycle must count as success.
    issue(32'h2000_0000);
    repeat (TIMEOUT - 1) tick();
    ack_bus(32'h7777_0001);
    wait_resp(d, ok);
    n_checks++;
    if (!ok || d !== 32'h7777_0001) $display("FAIL tmo_edge_ack: got %h ok=%0b want 77770001", d, ok);
    else n_pass++;
    tick();
    run_cmd(32'h0000_0000, d, ok);
    n_checks++;
    if (!ok || d !== 32'h0000_0020) $display("FAIL tmo_edge_status: got %h ok=%0b want 00000020", d, ok);
    else n_pass++;
  endtask
`else
  task automatic test_no_timeout();
    logic [31:0] d; bit ok;
    run_cmd(32'h1000_0020, d, ok);
    issue(32'h2000_0000);
    repeat (20) tick();
    n_checks++;
    if (bus_req !== 1'b1) $display("FAIL wait_forever_req: got %b want 1", bus_req);
    else n_pass++;
    ack_bus(32'h1111_2222);
    wait_resp(d, ok);
    n_checks++;
    if (!ok || d !== 32'h1111_2222) $display("FAIL late_ack_resp: got %h ok=%0b want 11112222", d, ok);
    else n_pass++;
    tick();
    run_cmd(32'h0000_0000, d, ok);
    n_checks++;
    if (!ok || d !== 32'h0000_0020) $display("FAIL no_tmo_status: got %h ok=%0b want 00000020", d, ok);
    else n_pass++;
  endtask
`endif

  task automatic test_overrun();
    logic [31:0] d; bit ok;
    run_cmd(32'h1000_0040, d, ok);
    issue(32'h2000_0000);
    issue(32'h1000_0080);
    ack_bus(32'hA5A5_5A5A);
    wait_resp(d, ok);
    n_checks++;
    if (!ok || d !== 32'hA5A5_5A5A) $display("FAIL ovr_first_resp: got %h ok=%0b want a5a55a5a", d, ok);
    else n_pass++;
    tick();
    run_cmd(32'h0000_0000, d, ok);
    n_checks++;
    if (!ok || d !== 32'h0002_0040) $display("FAIL ovr_status_set: got %h ok=%0b want 00020040", d, ok);
    else n_pass++;
    run_cmd(32'h0000_0000, d, ok);
    n_checks++;
    if (!ok || d !== 32'h0000_0040) $display("FAIL ovr_status_clr: got %h ok=%0b want 00000040", d, ok);
    else n_pass++;
  endtask

  task automatic test_reset_mid_bus();
    logic [31:0] d; bit ok;
    run_cmd(32'h1000_0044, d, ok);
    run_cmd(32'h3000_BEEF, d, ok);
    n_checks++;
    if (!ok || d !== 32'h3000_BEEF) $display("FAIL rst_pre_wlo: got %h ok=%0b want 3000beef", d, ok);
    else n_pass++;
    issue(32'h4000_0001);
    n_checks++;
    if (bus_req !== 1'b1) $display("FAIL rst_pre_req: got %b want 1", bus_req);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus_req, bus_we, resp_we} !== 3'b000)
      $display("FAIL rst_mid_strobes: got %b want 000", {bus_req, bus_we, resp_we});
    else n_pass++;
    n_checks++;
    if ({bus_addr, bus_wdata, resp_data} !== '0)
      $display("FAIL rst_mid_data: got %h/%h/%h want 0", bus_addr, bus_wdata, resp_data);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    run_cmd(32'h0000_0000, d, ok);
    n_checks++;
    if (!ok || d !== 32'h0000_0000) $display("FAIL rst_status: got %h ok=%0b want 00000000", d, ok);
    else n_pass++;
    issue(32'h4000_ABCD);
    n_checks++;
    if ({bus_addr, bus_wdata} !== {16'h0000, 32'hABCD_0000})
      $display("FAIL rst_wdata_clr: got addr=%h wdata=%h want 0000 abcd0000", bus_addr, bus_wdata);
    else n_pass++;
    ack_bus(32'h0);
    wait_resp(d, ok);
    n_checks++;
    if (!ok || d !== 32'h4000_0000) $display("FAIL rst_write_resp: got %h ok=%0b want 40000000", d, ok);
    else n_pass++;
    tick();
  endtask

  task automatic test_wrap_illegal();
    logic [31:0] d; bit ok;
    run_cmd(32'h1000_FFFF, d, ok);
    n_checks++;
    if (!ok || d !== 32'h1000_FFFC) $display("FAIL addr_align: got %h ok=%0b want 1000fffc", d, ok);
    else n_pass++;
    issue(32'h2800_0000);
    n_checks++;
    if (bus_addr !== 16'hFFFC) $display("FAIL wrap_bus_addr: got %h want fffc", bus_addr);
    else n_pass++;
    ack_bus(32'h1357_9BDF);
    wait_resp(d, ok);
    n_checks++;
    if (!ok || d !== 32'h1357_9BDF) $display("FAIL wrap_read: got %h ok=%0b want 13579bdf", d, ok);
    else n_pass++;
    tick();
    run_cmd(32'h0000_0000, d, ok);
    n_checks++;
    if (!ok || d !== 32'h0000_0000) $display("FAIL wrap_status: got %h ok=%0b want 00000000", d, ok);
    else n_pass++;
    run_cmd(32'h9000_0000, d, ok);
    n_checks++;
    if (!ok || d !== 32'hBAD0_0009) $display("FAIL illegal_op9: got %h ok=%0b want bad00009", d, ok);
    else n_pass++;
    run_cmd(32'hF123_4567, d, ok);
    n_checks++;
    if (!ok || d !== 32'hBAD0_000F) $display("FAIL illegal_opf: got %h ok=%0b want bad0000f", d, ok);
    else n_pass++;
    run_cmd(32'h0000_0000, d, ok);
    n_checks++;
    if (!ok || d !== 32'h0000_0000) $display("FAIL illegal_no_effect: got %h ok=%0b want 00000000", d, ok);
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_read_inc();
    test_write();
    test_ack_ignored();
`ifdef DBG_BUS_BRIDGE_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_overrun();
    test_reset_mid_bus();
    test_wrap_illegal();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
